instr_issuer: RTL

//  Drives the Simple RISC Machine cpu load/s/w instruction interface.

---
 rtl/instr_issuer_pkg.sv | 42 ++++
 rtl/instr_issuer_if.sv | 27 ++
 rtl/instr_issuer_ram.sv | 26 ++
 rtl/instr_issuer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared types for the instruction issuer: FSM encoding, instruction word,
// and SRM opcode field constants used to build test programs.
package instr_issuer_pkg;

  localparam int INSTR_W = 16;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  // Field layout: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  function automatic instr_t mk_mov_imm(input logic [2:0] rn, input logic [7:0] imm);
    return {OPC_MOV, MOV_IMM, rn, imm};
  endfunction

  function automatic instr_t mk_mov_reg(input logic [2:0] rd, input logic [1:0] sh,
                                        input logic [2:0] rm);
    return {OPC_MOV, MOV_REG, 3'b000, rd, sh, rm};
  endfunction

  function automatic instr_t mk_alu(input logic [1:0] op, input logic [2:0] rn,
                                    input logic [2:0] rd, input logic [1:0] sh,
                                    input logic [2:0] rm);
    return {OPC_ALU, op, rn, rd, sh, rm};
  endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// Instruction/handshake bundle between the issuer (master) and the SRM cpu (slave).
interface instr_issuer_if;
  import instr_issuer_pkg::*;

  instr_t     cpu_in;
  logic       cpu_load;
  logic       cpu_s;
  logic       cpu_w;
  logic [2:0] cpu_nvz;

  modport master (
    output cpu_in,
    output cpu_load,
    output cpu_s,
    input  cpu_w,
    input  cpu_nvz
  );

  modport slave (
    input  cpu_in,
    input  cpu_load,
    input  cpu_s,
    output cpu_w,
    output cpu_nvz
  );

endinterface

// File: rtl/instr_issuer_ram.sv
// Program store: 2**AW x 16 words, synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives a reset.
module issuer_ram
  import instr_issuer_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instr_t        wdata,
  input  logic [AW-1:0] raddr,
  output instr_t        rdata
);

  instr_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Issues a stored program to the SRM cpu one instruction at a time using the
// load / s / w handshake, capturing flags per instruction and flagging a hung cpu.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  instr_t        prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          go,
  instr_issuer_if.master cpu,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [2:0]    last_nvz
);

  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]     LEN_ONE = (AW+1)'(1);

  state_t        state_reg, state_next;
  logic [AW:0]   len_reg;
  logic [AW-1:0] pc_reg;
  logic [CW-1:0] tmo_reg;
  logic          err_reg;
  logic [2:0]    nvz_reg;
  instr_t        in_reg;
  instr_t        ram_rdata;
  logic          ram_we;
  logic          last_instr;
  logic          tmo_hit;

  // The program may only be edited while no run is in flight.
  assign ram_we = prog_we && (state_reg == ST_IDLE);

  issuer_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_reg),
    .rdata (ram_rdata)
  );

  assign last_instr = ({1'b0, pc_reg} == (len_reg - LEN_ONE));
  assign tmo_hit    = (tmo_reg == TO_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          state_next = (prog_len == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD:  state_next = ST_START;
      ST_START: state_next = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!cpu.cpu_w) begin
          state_next = ST_WAIT_HI;
        end else if (tmo_hit) begin
          state_next = ST_FIN;
        end
      end
      ST_WAIT_HI: begin
        if (cpu.cpu_w) begin
          state_next = last_instr ? ST_FIN : ST_LOAD;
        end else if (tmo_hit) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      pc_reg    <= '0;
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
      nvz_reg   <= '0;
      in_reg    <= '0;
    end else begin
      state_reg <= state_next;

      // Counter restarts on every state change, so it measures time spent in one wait phase.
      if (state_next != state_reg) begin
        tmo_reg <= '0;
      end else if ((state_reg == ST_WAIT_LO) || (state_reg == ST_WAIT_HI)) begin
        tmo_reg <= tmo_reg + CW'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            len_reg <= prog_len;
            err_reg <= 1'b0;
            pc_reg  <= '0;
          end
        end
        ST_LOAD: begin
          in_reg <= ram_rdata;
        end
        ST_WAIT_LO: begin
          if (cpu.cpu_w && tmo_hit) begin
            err_reg <= 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (cpu.cpu_w) begin
            nvz_reg <= cpu.cpu_nvz;
            if (!last_instr) begin
              pc_reg <= pc_reg + AW'(1);
            end
          end else if (tmo_hit) begin
            err_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The word is presented straight from RAM during LOAD and held from in_reg afterwards.
  assign cpu.cpu_in   = (state_reg == ST_LOAD) ? ram_rdata : in_reg;
  assign cpu.cpu_load = (state_reg == ST_LOAD);
  assign cpu.cpu_s    = (state_reg == ST_START);

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_FIN);
  assign err      = err_reg;
  assign pc       = pc_reg;
  assign last_nvz = nvz_reg;

endmodule
